// File: rtl/ipv4_rx_mw.sv
// IPv4 receive filter: checks the full header (fields, addresses, checksum) before
// forwarding payload, trims payload to Total Length and counts dropped packets.
module ipv4_rx_mw #(
    parameter int          DATA_W         = 16,
    parameter bit          MATCH_SRC_ADDR = 1'b1,
    parameter bit          MATCH_DST_ADDR = 1'b1,
    parameter logic [31:0] SRC_ADDR       = 32'hCEC8_7F80,
    parameter logic [31:0] DST_ADDR       = 32'hCEC8_7F80,
    parameter logic [7:0]  PROT_A         = 8'd17,
    parameter logic [7:0]  PROT_B         = 8'd17,
    parameter int          DROP_CNT_W     = 16,
    localparam int         LEN_W          = $clog2(DATA_W/8+1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic                  start_i,
    input  logic                  cancel_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [LEN_W-1:0]      len_i,
    output logic                  valid_o,
    output logic                  start_o,
    output logic                  last_o,
    output logic [DATA_W-1:0]     data_o,
    output logic [LEN_W-1:0]      len_o,
    output logic                  cancel_o,
    output logic                  cs_err_o,
    output logic                  drop_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    localparam int BPB     = DATA_W / 8;
    localparam int WPB     = DATA_W / 16;
    localparam int HDR_CAP = 20;

    typedef enum logic [1:0] {IDLE, HEAD, DATA, DRAIN} state_t;

    state_t state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] sum_reg, sum_next;
    logic [15:0] totlen_reg, totlen_next;
    logic        first_reg, first_next;
    logic [HDR_CAP-1:0][7:0] hdr_reg, hdr_cur;

    logic              valid_next, start_next, last_next, cancel_next, cs_err_next, drop_next;
    logic [DATA_W-1:0] data_next;
    logic [LEN_W-1:0]  len_next;

    logic        head_beat;
    logic [15:0] cnt_eff, sum_base, sum_cur, totlen_cur, rem, len_ext;
    logic [17:0] raw_sum;
    logic [16:0] fold_sum;
    logic [3:0]  ihl;
    logic [5:0]  ihl_bytes, hdr_len;
    logic [31:0] src_addr, dst_addr;
    logic        last_hdr, bad_cs, drop_cond, pl_last;

    assign head_beat = valid_i && !cancel_i && (start_i || state_reg == HEAD);
    assign cnt_eff   = start_i ? 16'd0 : cnt_reg;
    assign sum_base  = start_i ? 16'd0 : sum_reg;

    // Header beats are aligned, so each captured byte has a fixed lane and beat offset.
    genvar gi;
    generate
        for (gi = 0; gi < HDR_CAP; gi++) begin : g_hdr
            localparam int          LANE = gi % BPB;
            localparam logic [15:0] BASE = 16'(gi - LANE);
            assign hdr_cur[gi] = (head_beat && cnt_eff == BASE) ? data_i[8*LANE +: 8] : hdr_reg[gi];
        end
    endgenerate

    always_comb begin
        raw_sum = {2'b00, sum_base};
        for (int k = 0; k < WPB; k++)
            raw_sum = raw_sum + {2'b00, data_i[16*k +: 8], data_i[16*k+8 +: 8]};
    end
    // End-around carry folded twice so the running sum always fits 16 bits.
    assign fold_sum = {1'b0, raw_sum[15:0]} + {15'd0, raw_sum[17:16]};
    assign sum_cur  = fold_sum[15:0] + {15'd0, fold_sum[16]};

    assign ihl        = hdr_cur[0][3:0];
    assign ihl_bytes  = {ihl, 2'b00};
    assign hdr_len    = (ihl < 4'd5) ? 6'd20 : ihl_bytes;
    assign totlen_cur = {hdr_cur[2], hdr_cur[3]};
    assign src_addr   = {hdr_cur[12], hdr_cur[13], hdr_cur[14], hdr_cur[15]};
    assign dst_addr   = {hdr_cur[16], hdr_cur[17], hdr_cur[18], hdr_cur[19]};
    assign last_hdr   = head_beat && (cnt_eff + 16'(BPB) == {10'd0, hdr_len});
    assign bad_cs     = sum_cur != 16'hFFFF;

    assign drop_cond = (hdr_cur[0][7:4] != 4'd4) || (ihl < 4'd5) ||
                       (totlen_cur < {10'd0, ihl_bytes}) ||
                       hdr_cur[6][5] || ({hdr_cur[6][4:0], hdr_cur[7]} != 13'd0) ||
                       (hdr_cur[8] == 8'd0) ||
                       ((hdr_cur[9] != PROT_A) && (hdr_cur[9] != PROT_B)) ||
                       (MATCH_SRC_ADDR && (src_addr != SRC_ADDR)) ||
                       (MATCH_DST_ADDR && (dst_addr != DST_ADDR)) ||
                       bad_cs;

    logic unused_hdr;
    assign unused_hdr = ^{hdr_cur[1], hdr_cur[4], hdr_cur[5], hdr_cur[6][7:6], hdr_cur[10], hdr_cur[11]};

    assign rem     = totlen_reg - cnt_reg;
    assign len_ext = 16'(len_i);
    assign pl_last = len_ext >= rem;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        sum_next    = sum_reg;
        totlen_next = totlen_reg;
        first_next  = first_reg;
        valid_next  = 1'b0;
        start_next  = 1'b0;
        last_next   = 1'b0;
        data_next   = '0;
        len_next    = '0;
        cancel_next = 1'b0;
        cs_err_next = 1'b0;
        drop_next   = 1'b0;
        if (cancel_i) begin
            cancel_next = (state_reg == DATA);
            state_next  = IDLE;
        end else if (valid_i) begin
            if (start_i || state_reg == HEAD) begin
                cancel_next = start_i && (state_reg == DATA);
                sum_next    = sum_cur;
                cnt_next    = cnt_eff + 16'(BPB);
                if (last_hdr) begin
                    totlen_next = totlen_cur;
                    if (drop_cond) begin
                        state_next  = DRAIN;
                        drop_next   = 1'b1;
                        cs_err_next = bad_cs;
                    end else if (totlen_cur == {10'd0, hdr_len}) begin
                        state_next = DRAIN;
                    end else begin
                        state_next = DATA;
                        first_next = 1'b1;
                    end
                end else begin
                    state_next = HEAD;
                end
            end else if (state_reg == DATA) begin
                valid_next = 1'b1;
                start_next = first_reg;
                first_next = 1'b0;
                data_next  = data_i;
                cnt_next   = cnt_reg + len_ext;
                if (pl_last) begin
                    last_next  = 1'b1;
                    len_next   = rem[LEN_W-1:0];
                    state_next = DRAIN;
                end else begin
                    len_next = len_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        hdr_reg <= hdr_cur;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            totlen_reg <= '0;
            first_reg  <= 1'b0;
            valid_o    <= 1'b0;
            start_o    <= 1'b0;
            last_o     <= 1'b0;
            data_o     <= '0;
            len_o      <= '0;
            cancel_o   <= 1'b0;
            cs_err_o   <= 1'b0;
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            sum_reg    <= sum_next;
            totlen_reg <= totlen_next;
            first_reg  <= first_next;
            valid_o    <= valid_next;
            start_o    <= start_next;
            last_o     <= last_next;
            data_o     <= data_next;
            len_o      <= len_next;
            cancel_o   <= cancel_next;
            cs_err_o   <= cs_err_next;
            drop_o     <= drop_next;
            if (drop_next && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_ipv4_rx_mw.sv
// Bench for ipv4_rx_mw: a 16-bit and a 32-bit instance driven with table-built packets
// plus hand sequences for cancel, restart, saturation and mid-packet reset.
module tb_ipv4_rx_mw;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic v16, s16, c16;
    logic [15:0] d16;
    logic [1:0]  l16;
    logic vo16, so16, lo16, co16, ce16, dr16;
    logic [15:0] do16;
    logic [1:0]  ln16;
    logic [15:0] dc16;

    logic v32, s32, c32;
    logic [31:0] d32;
    logic [2:0]  l32;
    logic vo32, so32, lo32, co32, ce32, dr32;
    logic [31:0] do32;
    logic [2:0]  ln32;
    logic [1:0]  dc32;

    ipv4_rx_mw #(.DATA_W(16)) u16 (
        .clk(clk), .reset(reset), .valid_i(v16), .start_i(s16), .cancel_i(c16),
        .data_i(d16), .len_i(l16), .valid_o(vo16), .start_o(so16), .last_o(lo16),
        .data_o(do16), .len_o(ln16), .cancel_o(co16), .cs_err_o(ce16), .drop_o(dr16),
        .drop_cnt_o(dc16));

    ipv4_rx_mw #(.DATA_W(32), .DROP_CNT_W(2)) u32 (
        .clk(clk), .reset(reset), .valid_i(v32), .start_i(s32), .cancel_i(c32),
        .data_i(d32), .len_i(l32), .valid_o(vo32), .start_o(so32), .last_o(lo32),
        .data_o(do32), .len_o(ln32), .cancel_o(co32), .cs_err_o(ce32), .drop_o(dr32),
        .drop_cnt_o(dc32));

    localparam logic [31:0] ADDR_OK  = 32'hCEC8_7F80;
    localparam logic [31:0] ADDR_BAD = 32'hCEC8_7F81;

    typedef struct {
        int          w;
        logic [3:0]  ver;
        logic [3:0]  ihl;
        int          totlen;
        bit          mf;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [31:0] dst;
        bit          cs_flip;
        int          mac_len;
        int          exp_beats;
        int          exp_last_len;
        bit          exp_drop;
        bit          exp_cs;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          len;
        bit          st;
        bit          la;
        int          cyc;
    } beat_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t q16[$], q32[$];
    beat_t mon_b;
    int drops16 = 0, cse16 = 0, canc16 = 0, canc_cyc16 = 0;
    int drops32 = 0, cse32 = 0, canc32 = 0, canc_cyc32 = 0;

    always @(negedge clk) begin
        if (vo16) begin
            mon_b.data = {16'd0, do16}; mon_b.len = int'(ln16);
            mon_b.st = so16; mon_b.la = lo16; mon_b.cyc = cyc;
            q16.push_back(mon_b);
        end
        if (vo32) begin
            mon_b.data = do32; mon_b.len = int'(ln32);
            mon_b.st = so32; mon_b.la = lo32; mon_b.cyc = cyc;
            q32.push_back(mon_b);
        end
        if (dr16) drops16++;
        if (ce16) cse16++;
        if (co16) begin canc16++; canc_cyc16 = cyc; end
        if (dr32) drops32++;
        if (ce32) cse32++;
        if (co32) begin canc32++; canc_cyc32 = cyc; end
    end

    int n_pass = 0, n_tot = 0;
    int exp_dc16 = 0, exp_dc32 = 0;
    logic [7:0] pkt_b [0:127];
    int pkt_n, pkt_hl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input int w, input logic [3:0] ver, input logic [3:0] ihl,
                                input int totlen, input bit mf, input logic [7:0] ttl,
                                input logic [7:0] proto, input logic [31:0] dst, input bit flip,
                                input int mac, input int eb, input int el, input bit ed, input bit ec);
        vec_t v;
        v.w = w; v.ver = ver; v.ihl = ihl; v.totlen = totlen; v.mf = mf; v.ttl = ttl;
        v.proto = proto; v.dst = dst; v.cs_flip = flip; v.mac_len = mac;
        v.exp_beats = eb; v.exp_last_len = el; v.exp_drop = ed; v.exp_cs = ec;
        return v;
    endfunction

    task automatic build_pkt(input vec_t v);
        int s, hl;
        logic [15:0] tl, cs;
        hl = (v.ihl < 4'd5) ? 20 : 4 * int'(v.ihl);
        for (int i = 0; i < 128; i++) pkt_b[i] = 8'(i * 13 + 5);
        tl = 16'(v.totlen);
        pkt_b[0] = {v.ver, v.ihl}; pkt_b[1] = 8'h00; pkt_b[2] = tl[15:8]; pkt_b[3] = tl[7:0];
        pkt_b[4] = 8'h12; pkt_b[5] = 8'h34; pkt_b[6] = {2'b00, v.mf, 5'b00000}; pkt_b[7] = 8'h00;
        pkt_b[8] = v.ttl; pkt_b[9] = v.proto; pkt_b[10] = 8'h00; pkt_b[11] = 8'h00;
        pkt_b[12] = 8'hCE; pkt_b[13] = 8'hC8; pkt_b[14] = 8'h7F; pkt_b[15] = 8'h80;
        pkt_b[16] = v.dst[31:24]; pkt_b[17] = v.dst[23:16]; pkt_b[18] = v.dst[15:8]; pkt_b[19] = v.dst[7:0];
        for (int i = 20; i < hl; i++) pkt_b[i] = 8'(i * 17);
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({pkt_b[i], pkt_b[i+1]});
        while (s > 65535) s = (s & 65535) + (s >>> 16);
        cs = ~16'(s);
        pkt_b[10] = cs[15:8];
        pkt_b[11] = cs[7:0] ^ (v.cs_flip ? 8'h01 : 8'h00);
        pkt_n = v.mac_len;
        pkt_hl = hl;
    endtask

    task automatic drive_beat(input int w, input bit st, input int off);
        int n;
        n = pkt_n - off;
        if (n > w / 8) n = w / 8;
        @(posedge clk); #1;
        v16 = 1'b0; s16 = 1'b0; c16 = 1'b0; v32 = 1'b0; s32 = 1'b0; c32 = 1'b0;
        if (w == 16) begin
            v16 = 1'b1; s16 = st; l16 = 2'(n);
            d16 = {pkt_b[off+1], pkt_b[off]};
        end else begin
            v32 = 1'b1; s32 = st; l32 = 3'(n);
            d32 = {pkt_b[off+3], pkt_b[off+2], pkt_b[off+1], pkt_b[off]};
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            v16 = 1'b0; s16 = 1'b0; c16 = 1'b0; v32 = 1'b0; s32 = 1'b0; c32 = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int q0, d0, e0, k0, bpb, pl_cyc, nb, elen;
        logic [31:0] dc, edc, mask, expw;
        beat_t bt;
        bpb = v.w / 8;
        if (v.w == 16) begin q0 = q16.size(); d0 = drops16; e0 = cse16; k0 = canc16; end
        else begin q0 = q32.size(); d0 = drops32; e0 = cse32; k0 = canc32; end
        build_pkt(v);
        pl_cyc = -1;
        for (int off = 0; off < pkt_n; off += bpb) begin
            drive_beat(v.w, off == 0, off);
            if (off == pkt_hl) pl_cyc = cyc;
        end
        idle(3);
        if (v.exp_drop) begin
            if (v.w == 16) begin if (exp_dc16 != 65535) exp_dc16++; end
            else begin if (exp_dc32 != 3) exp_dc32++; end
        end
        if (v.w == 16) begin
            nb = q16.size() - q0;
            chk($sformatf("v%0d drop", idx), drops16 - d0, v.exp_drop);
            chk($sformatf("v%0d cs_err", idx), cse16 - e0, v.exp_cs);
            chk($sformatf("v%0d cancel", idx), canc16 - k0, 0);
            dc = 32'(dc16); edc = 32'(exp_dc16);
        end else begin
            nb = q32.size() - q0;
            chk($sformatf("v%0d drop", idx), drops32 - d0, v.exp_drop);
            chk($sformatf("v%0d cs_err", idx), cse32 - e0, v.exp_cs);
            chk($sformatf("v%0d cancel", idx), canc32 - k0, 0);
            dc = 32'(dc32); edc = 32'(exp_dc32);
        end
        chk($sformatf("v%0d drop_cnt", idx), dc, edc);
        chk($sformatf("v%0d beats", idx), nb, v.exp_beats);
        if (nb == v.exp_beats) begin
            for (int j = 0; j < nb; j++) begin
                if (v.w == 16) bt = q16[q0 + j]; else bt = q32[q0 + j];
                elen = (j == nb - 1) ? v.exp_last_len : bpb;
                mask = '0; expw = '0;
                for (int b = 0; b < elen; b++) begin
                    mask[8*b +: 8] = 8'hFF;
                    expw[8*b +: 8] = pkt_b[pkt_hl + j * bpb + b];
                end
                chk($sformatf("v%0d b%0d start", idx, j), bt.st, j == 0);
                chk($sformatf("v%0d b%0d last", idx, j), bt.la, j == nb - 1);
                chk($sformatf("v%0d b%0d len", idx, j), bt.len, elen);
                chk($sformatf("v%0d b%0d data", idx, j), bt.data & mask, expw);
                if (j == 0) chk($sformatf("v%0d latency", idx), bt.cyc, pl_cyc + 1);
            end
        end
    endtask

    vec_t vt [14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k0, d0, q0, ccyc;
        vt[0]  = mk(16, 4'd4, 4'd5, 28, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 28, 4, 2, 1'b0, 1'b0);
        vt[1]  = mk(32, 4'd4, 4'd5, 31, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 35, 3, 3, 1'b0, 1'b0);
        vt[2]  = mk(16, 4'd4, 4'd5, 28, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b1, 28, 0, 0, 1'b1, 1'b1);
        vt[3]  = mk(32, 4'd4, 4'd7, 40, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 40, 3, 4, 1'b0, 1'b0);
        vt[4]  = mk(32, 4'd4, 4'd5, 28, 1'b1, 8'd64, 8'd17, ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[5]  = mk(32, 4'd4, 4'd5, 28, 1'b0, 8'd0,  8'd17, ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[6]  = mk(32, 4'd4, 4'd5, 28, 1'b0, 8'd64, 8'd6,  ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[7]  = mk(32, 4'd4, 4'd5, 28, 1'b0, 8'd64, 8'd17, ADDR_BAD, 1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[8]  = mk(32, 4'd4, 4'd5, 28, 1'b0, 8'd0,  8'd17, ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[9]  = mk(16, 4'd4, 4'd5, 20, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 24, 0, 0, 1'b0, 1'b0);
        vt[10] = mk(16, 4'd6, 4'd5, 28, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[11] = mk(16, 4'd4, 4'd4, 28, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 28, 0, 0, 1'b1, 1'b0);
        vt[12] = mk(16, 4'd4, 4'd5, 18, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 24, 0, 0, 1'b1, 1'b0);
        vt[13] = mk(16, 4'd4, 4'd5, 27, 1'b0, 8'd64, 8'd17, ADDR_OK,  1'b0, 30, 4, 1, 1'b0, 1'b0);

        reset = 1'b1;
        v16 = 1'b0; s16 = 1'b0; c16 = 1'b0; d16 = '0; l16 = '0;
        v32 = 1'b0; s32 = 1'b0; c32 = 1'b0; d32 = '0; l32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst valid16", vo16, 0);   chk("rst start16", so16, 0); chk("rst last16", lo16, 0);
        chk("rst data16", do16, 0);    chk("rst len16", ln16, 0);   chk("rst cancel16", co16, 0);
        chk("rst cs_err16", ce16, 0);  chk("rst drop16", dr16, 0);  chk("rst cnt16", dc16, 0);
        chk("rst valid32", vo32, 0);   chk("rst cnt32", dc32, 0);
        @(posedge clk); #1 reset = 1'b0;
        idle(2);

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Cancel two beats into an accepted 32-bit packet, then a normal packet.
        build_pkt(mk(32, 4'd4, 4'd5, 40, 1'b0, 8'd64, 8'd17, ADDR_OK, 1'b0, 40, 5, 4, 1'b0, 1'b0));
        q0 = q32.size(); k0 = canc32; d0 = drops32;
        for (int off = 0; off <= 24; off += 4) drive_beat(32, off == 0, off);
        @(posedge clk); #1;
        v32 = 1'b0; s32 = 1'b0; c32 = 1'b1; ccyc = cyc;
        @(posedge clk); #1 c32 = 1'b0;
        idle(3);
        chk("cancel beats", q32.size() - q0, 2);
        chk("cancel pulses", canc32 - k0, 1);
        chk("cancel timing", canc_cyc32, ccyc + 1);
        chk("cancel no drop", drops32 - d0, 0);
        run_vec(vt[1], 100);

        // Cancel during the header: silent abandon.
        build_pkt(vt[1]);
        k0 = canc32; d0 = drops32;
        drive_beat(32, 1'b1, 0);
        drive_beat(32, 1'b0, 4);
        @(posedge clk); #1;
        v32 = 1'b0; s32 = 1'b0; c32 = 1'b1;
        idle(3);
        chk("hdr cancel drop", drops32 - d0, 0);
        chk("hdr cancel cancel_o", canc32 - k0, 0);

        // Restart via start_i in the middle of a 16-bit header.
        build_pkt(vt[0]);
        for (int off = 0; off <= 4; off += 2) drive_beat(16, off == 0, off);
        run_vec(vt[0], 101);

        // Reset mid-payload clears every output and the counters.
        build_pkt(vt[0]);
        k0 = canc16;
        for (int off = 0; off <= 22; off += 2) drive_beat(16, off == 0, off);
        @(posedge clk); #1;
        v16 = 1'b0; s16 = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst valid16", vo16, 0);  chk("midrst last16", lo16, 0);
        chk("midrst len16", ln16, 0);    chk("midrst cancel16", co16, 0);
        chk("midrst cnt16", dc16, 0);    chk("midrst cnt32", dc32, 0);
        @(posedge clk); #1 reset = 1'b0;
        exp_dc16 = 0; exp_dc32 = 0;
        idle(3);
        chk("midrst no cancel", canc16 - k0, 0);
        run_vec(vt[13], 102);
        run_vec(vt[2], 103);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
